csi2_pkt_handler_mc: RTL and testbench
======================================

// Module: csi2_pkt_handler_mc
// PURPOSE
//  Parametrised multi-channel successor to the CSI-2 packet handler. Takes the merged
//  lane byte stream (header beat followed by payload beats), decodes packet headers,
//  strips headers and CRC, and forwards long-packet payload with correct tlast/tstrb.
//  Adds: generic beat width, virtual-channel filtering, a per-VC sync-event bus,
//  a true ready/valid output register (backpressure safe) and an oversize-packet error.
//  Sits between the lane merger and the pixel unpacker.
// PARAMETERS
//  BYTES_PER_BEAT  4      payload bytes per beat; legal values 4 or 8.
//  VC_MASK         4'hF   bit v=1 forwards VC v; a 0 bit consumes and drops that VC.
//  MAX_WC          16'hFFFF  a long-packet WC above this value is an error and the packet is dropped.
// PORTS
//  clk_i          in   1                 sole clock
//  rst_n_i        in   1                 asynchronous, active-low reset
//  pkt_i          axi4_stream_if.slave   TDATA_WIDTH=8*BYTES_PER_BEAT, lane-merged bytes
//  pkt_o          axi4_stream_if.master  same width; payload only
//  frame_start_o  out  4                 one-cycle pulse per VC, short packet DT 0x00
//  frame_end_o    out  4                 one-cycle pulse per VC, DT 0x01
//  line_start_o   out  4                 one-cycle pulse per VC, DT 0x02
//  line_end_o     out  4                 one-cycle pulse per VC, DT 0x03
//  pkt_err_o      out  1                 one-cycle pulse: long packet with WC>MAX_WC
// BEHAVIOUR
//  - Header beat: tdata[5:0]=DT, [7:6]=VC, [23:8]=WC; header bytes never share a beat
//    with payload, and the upper header-beat bytes are ignored. DT<0x10 is a short packet.
//    DT>=0x10 is a long packet.
//  - Input handshake: pkt_i.tready = !pkt_o.tvalid || pkt_o.tready (single output register).
//    A beat is accepted on tvalid&&tready. Nothing is lost or duplicated under backpressure.
//  - FSM IDLE->RUN on an accepted long header with 0<WC<=MAX_WC.
//    - WC==0: stay IDLE, no output.
//    - WC>MAX_WC: go to DROP and pulse pkt_err_o.
//    RUN: byte_cnt += BYTES_PER_BEAT per accepted beat. On the beat where byte_cnt+B>=WC:
//      -> CRC_S if (B - rem) < 2, where rem = WC mod B, with rem==0 treated as B;
//      -> IDLE otherwise.
//    CRC_S: consume one beat, emit nothing, then -> IDLE.
//    DROP: identical counting to RUN/CRC_S, but no output.
//  - Packets on a VC whose VC_MASK bit is 0 take the DROP path, with no error pulse.
//  - Output: pkt_o.tvalid set for each accepted RUN beat; latency is 1 cycle.
//    - tdata is a copy of the input beat.
//    - tid = VC.
//    - tuser[0] = 1 on the first payload beat of a packet.
//    - tdest = 0.
//    - tstrb = tkeep = all ones, except on the last beat, where it is (1<<rem)-1 and tlast=1.
//    - The output register holds its contents while pkt_o.tready=0.
//  - Short packets: the matching per-VC pulse fires in the cycle after header acceptance.
//    Pulses fire even when VC_MASK drops that VC. Other DT<0x10 values are consumed silently.
//  - Header detection happens only in IDLE; payload bytes never decode as headers.
//  - byte_cnt width is 17 bits, so WC=0xFFFF plus a partial beat does not wrap.
//  - Reset (asynchronous, anytime, including mid-packet):
//    - state=IDLE, byte_cnt=0.
//    - pkt_o.tvalid/tlast/tuser = 0, tstrb = 0.
//    - All pulse outputs = 0.
//    - The next accepted beat is treated as a header.
// STRUCTURE
//  - csi2_data_types_pkg gains: DT codes FRAME_START/FRAME_END/LINE_START/LINE_END,
//    LONG_PKT_MIN_DT=6'h10, typedef csi2_hdr_t (dt, vc, wc, ecc), and a state enum.
//  - One sub-module, csi2_pkt_hdr_decode: combinational header unpack plus is_long, is_sync
//    and per-VC one-hot decode. Everything else lives in this module.
// TESTING
//  1. B=4, VC0 header WC=6, 2 payload beats + CRC -> beat0 tstrb=F, beat1 tstrb=3 tlast=1.
//     No CRC beat is forwarded.
//  2. B=4, WC=8 -> 2 full beats (tlast on the 2nd, tstrb=F); the next all-CRC beat is
//     swallowed and the FSM is back in IDLE.
//  3. B=8, WC=7 -> one beat, tstrb=7F, tlast=1, followed by one CRC beat dropped;
//     B=8, WC=5 -> no CRC beat.
//  4. FS VC2 then FE VC2 short packets -> frame_start_o=4'b0100 for 1 cycle, then
//     frame_end_o=4'b0100 for 1 cycle.
//  5. VC_MASK=4'h1, long packet on VC1 -> no pkt_o beats, no error; a following VC0 packet
//     passes intact. WC=MAX_WC+1 -> pkt_err_o pulse and packet dropped.
//  6. Random pkt_o.tready deassertion plus rst_n_i asserted mid-packet -> no beat lost or
//     duplicated, and all outputs zero immediately; after release the first beat is decoded
//     as a header.

Source files
------------

// File: rtl/csi2_data_types_pkg.sv
// Shared CSI-2 definitions: data-type codes, the packet header layout and the
// packet handler state encoding.
package csi2_data_types_pkg;

  // Short-packet synchronisation data types
  localparam logic [5:0] DT_FRAME_START  = 6'h00;
  localparam logic [5:0] DT_FRAME_END    = 6'h01;
  localparam logic [5:0] DT_LINE_START   = 6'h02;
  localparam logic [5:0] DT_LINE_END     = 6'h03;

  // Data types at or above this value carry a payload
  localparam logic [5:0] LONG_PKT_MIN_DT = 6'h10;

  // Header layout as it appears in the low 32 bits of a header beat
  typedef struct packed {
    logic [7:0]  ecc;
    logic [15:0] wc;
    logic [1:0]  vc;
    logic [5:0]  dt;
  } csi2_hdr_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StCrcS,
    StDrop
  } csi2_pkt_state_e;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle used on both sides of the packet handler.
//   master: drives tdata/tstrb/tkeep/tlast/tid/tdest/tuser/tvalid, samples tready
//   slave : samples the above, drives tready
interface axi4_stream_if #(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned TID_WIDTH   = 2,
  parameter int unsigned TDEST_WIDTH = 2,
  parameter int unsigned TUSER_WIDTH = 1
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic                     tvalid;
  logic                     tready;

  modport master (
    output tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/csi2_pkt_hdr_decode.sv
// Combinational CSI-2 header unpack.
//   i_beat      : low 32 bits of the candidate header beat
//   o_hdr       : unpacked header fields
//   o_is_long   : DT carries a payload
//   o_is_sync   : DT is one of the four frame/line sync codes
//   o_vc_onehot : one-hot of the header VC
//   o_sync_sel  : one-hot {LE, LS, FE, FS} of the sync code
module csi2_pkt_hdr_decode
  import csi2_data_types_pkg::*;
(
  input  logic [31:0] i_beat,
  output csi2_hdr_t   o_hdr,
  output logic        o_is_long,
  output logic        o_is_sync,
  output logic [3:0]  o_vc_onehot,
  output logic [3:0]  o_sync_sel
);

  always_comb begin
    o_hdr       = csi2_hdr_t'(i_beat);
    o_is_long   = (o_hdr.dt >= LONG_PKT_MIN_DT);
    o_is_sync   = (o_hdr.dt <= DT_LINE_END);
    o_vc_onehot = 4'b0001 << o_hdr.vc;
    o_sync_sel  = 4'b0000;
    case (o_hdr.dt)
      DT_FRAME_START: o_sync_sel = 4'b0001;
      DT_FRAME_END:   o_sync_sel = 4'b0010;
      DT_LINE_START:  o_sync_sel = 4'b0100;
      DT_LINE_END:    o_sync_sel = 4'b1000;
      default:        o_sync_sel = 4'b0000;
    endcase
  end

endmodule

// File: rtl/csi2_pkt_handler_mc.sv
// Multi-channel CSI-2 packet handler. Decodes headers from the lane-merged beat
// stream, forwards long-packet payload (headers and CRC stripped) through a single
// ready/valid output register and raises per-VC sync pulses.
//   clk_i, rst_n_i      : clock, asynchronous active-low reset
//   pkt_i               : lane-merged input beats (header beat, then payload beats)
//   pkt_o               : payload beats; tid=VC, tuser[0]=first beat, tlast/tstrb on last
//   frame_start_o ..    : one-cycle per-VC pulses for FS/FE/LS/LE short packets
//   pkt_err_o           : one-cycle pulse when a long packet exceeds MAX_WC
module csi2_pkt_handler_mc
  import csi2_data_types_pkg::*;
#(
  parameter int unsigned BYTES_PER_BEAT = 4,
  parameter logic [3:0]  VC_MASK        = 4'hF,
  parameter logic [15:0] MAX_WC         = 16'hFFFF
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o,
  output logic [3:0]    frame_start_o,
  output logic [3:0]    frame_end_o,
  output logic [3:0]    line_start_o,
  output logic [3:0]    line_end_o,
  output logic          pkt_err_o
);

  localparam int unsigned SW = BYTES_PER_BEAT;
  localparam int unsigned DW = 8 * SW;
  localparam int unsigned RW = $clog2(SW);
  localparam logic [RW:0] BEAT_BYTES = BYTES_PER_BEAT[RW:0];
  localparam logic [16:0] BEAT_INC   = BYTES_PER_BEAT[16:0];

  csi2_pkt_state_e r_state, w_state_nxt;

  // Per-packet context captured from the header
  logic [16:0]   r_byte_cnt;
  logic [15:0]   r_wc;
  logic [SW-1:0] r_last_strb;
  logic          r_crc_spill;
  logic [1:0]    r_vc;
  logic          r_first;

  // Output register
  logic          r_vld;
  logic [DW-1:0] r_data;
  logic [SW-1:0] r_strb;
  logic          r_last;
  logic          r_user;
  logic [1:0]    r_id;

  logic [3:0]    r_fs, r_fe, r_ls, r_le;
  logic          r_err;

  csi2_hdr_t     w_hdr;
  logic          w_is_long, w_is_sync;
  logic [3:0]    w_vc_onehot, w_sync_sel;
  logic          w_vc_en, w_wc_zero, w_wc_big;
  logic [RW:0]   w_rem, w_gap;
  logic [SW-1:0] w_strb_hdr;
  logic          w_spill_hdr;
  logic          w_in_ready, w_accept, w_hdr_acc, w_emit;
  logic [16:0]   w_cnt_sum;
  logic          w_last_beat;
  logic          w_unused;

  csi2_pkt_hdr_decode u_hdr_decode (
    .i_beat      (pkt_i.tdata[31:0]),
    .o_hdr       (w_hdr),
    .o_is_long   (w_is_long),
    .o_is_sync   (w_is_sync),
    .o_vc_onehot (w_vc_onehot),
    .o_sync_sel  (w_sync_sel)
  );

  // Last-beat geometry, precomputed while the header is on the bus
  always_comb begin
    w_vc_en   = |(w_vc_onehot & VC_MASK);
    w_wc_zero = (w_hdr.wc == 16'h0000);
    w_wc_big  = (w_hdr.wc > MAX_WC);
    w_rem     = {1'b0, w_hdr.wc[RW-1:0]};
    if (w_rem == '0) begin
      w_rem = BEAT_BYTES;
    end
    w_gap       = BEAT_BYTES - w_rem;
    w_strb_hdr  = {SW{1'b1}} >> w_gap;
    // Fewer than two spare bytes: the CRC spills into one more beat
    w_spill_hdr = (w_gap[RW:1] == '0);
  end

  assign w_in_ready  = !r_vld || pkt_o.tready;
  assign w_accept    = pkt_i.tvalid && w_in_ready;
  assign w_hdr_acc   = w_accept && (r_state == StIdle);
  assign w_emit      = w_accept && (r_state == StRun);
  assign w_cnt_sum   = r_byte_cnt + BEAT_INC;
  assign w_last_beat = (w_cnt_sum >= {1'b0, r_wc});

  assign w_unused = ^{w_hdr.ecc, w_hdr.dt, pkt_i.tstrb, pkt_i.tkeep, pkt_i.tlast,
                      pkt_i.tid, pkt_i.tdest, pkt_i.tuser};

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept && w_is_long && !w_wc_zero) begin
          w_state_nxt = (w_vc_en && !w_wc_big) ? StRun : StDrop;
        end
      end
      StRun, StDrop: begin
        if (w_accept && w_last_beat) begin
          w_state_nxt = r_crc_spill ? StCrcS : StIdle;
        end
      end
      StCrcS: begin
        if (w_accept) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Packet context, output register and pulse registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_byte_cnt  <= '0;
      r_wc        <= '0;
      r_last_strb <= '0;
      r_crc_spill <= 1'b0;
      r_vc        <= '0;
      r_first     <= 1'b0;
      r_vld       <= 1'b0;
      r_data      <= '0;
      r_strb      <= '0;
      r_last      <= 1'b0;
      r_user      <= 1'b0;
      r_id        <= '0;
      r_fs        <= '0;
      r_fe        <= '0;
      r_ls        <= '0;
      r_le        <= '0;
      r_err       <= 1'b0;
    end else begin
      r_fs  <= '0;
      r_fe  <= '0;
      r_ls  <= '0;
      r_le  <= '0;
      r_err <= 1'b0;

      if (w_hdr_acc) begin
        r_byte_cnt  <= '0;
        r_wc        <= w_hdr.wc;
        r_last_strb <= w_strb_hdr;
        r_crc_spill <= w_spill_hdr;
        r_vc        <= w_hdr.vc;
        r_first     <= 1'b1;
        // Sync pulses ignore VC_MASK
        if (w_is_sync) begin
          r_fs <= w_sync_sel[0] ? w_vc_onehot : 4'h0;
          r_fe <= w_sync_sel[1] ? w_vc_onehot : 4'h0;
          r_ls <= w_sync_sel[2] ? w_vc_onehot : 4'h0;
          r_le <= w_sync_sel[3] ? w_vc_onehot : 4'h0;
        end
        // Masked VCs are dropped silently, so only enabled VCs report oversize
        r_err <= w_is_long && !w_wc_zero && w_vc_en && w_wc_big;
      end else if (w_accept && (r_state == StRun || r_state == StDrop)) begin
        r_byte_cnt <= w_cnt_sum;
        r_first    <= 1'b0;
      end

      if (w_in_ready) begin
        r_vld <= w_emit;
        if (w_emit) begin
          r_data <= pkt_i.tdata;
          r_strb <= w_last_beat ? r_last_strb : {SW{1'b1}};
          r_last <= w_last_beat;
          r_user <= r_first;
          r_id   <= r_vc;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    pkt_i.tready  = w_in_ready;
    pkt_o.tvalid  = r_vld;
    pkt_o.tdata   = r_data;
    pkt_o.tstrb   = r_strb;
    pkt_o.tkeep   = r_strb;
    pkt_o.tlast   = r_last;
    pkt_o.tuser   = r_user;
    pkt_o.tid     = r_id;
    pkt_o.tdest   = '0;
    frame_start_o = r_fs;
    frame_end_o   = r_fe;
    line_start_o  = r_ls;
    line_end_o    = r_le;
    pkt_err_o     = r_err;
  end

endmodule

// File: tb/tb_csi2_pkt_handler_mc.sv
// Directed bench for csi2_pkt_handler_mc: a 4-byte instance (VC_MASK=1, MAX_WC=16)
// with a monitored output queue and an 8-byte instance checked beat by beat.
module tb_csi2_pkt_handler_mc;

  typedef struct packed {
    logic [1:0]  id;
    logic [1:0]  dest;
    logic        user;
    logic        last;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(32)) a_in ();
  axi4_stream_if #(.TDATA_WIDTH(32)) a_out ();
  axi4_stream_if #(.TDATA_WIDTH(64)) b_in ();
  axi4_stream_if #(.TDATA_WIDTH(64)) b_out ();

  logic [3:0] fs_a, fe_a, ls_a, le_a, fs_b, fe_b, ls_b, le_b;
  logic       err_a, err_b;

  csi2_pkt_handler_mc #(
    .BYTES_PER_BEAT (4),
    .VC_MASK        (4'h1),
    .MAX_WC         (16'h0010)
  ) u_dut_a (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .pkt_i         (a_in),
    .pkt_o         (a_out),
    .frame_start_o (fs_a),
    .frame_end_o   (fe_a),
    .line_start_o  (ls_a),
    .line_end_o    (le_a),
    .pkt_err_o     (err_a)
  );

  csi2_pkt_handler_mc #(
    .BYTES_PER_BEAT (8),
    .VC_MASK        (4'hF),
    .MAX_WC         (16'hFFFF)
  ) u_dut_b (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .pkt_i         (b_in),
    .pkt_o         (b_out),
    .frame_start_o (fs_b),
    .frame_end_o   (fe_b),
    .line_start_o  (ls_b),
    .line_end_o    (le_b),
    .pkt_err_o     (err_b)
  );

  assign b_out.tready = 1'b1;

  int n_total = 0;
  int n_pass  = 0;
  int err_cnt_a = 0;
  int tready_mode = 0;  // 0: always ready, 1: random, 2: held low
  beat_t q_a[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] hdr(input logic [5:0] dt, input logic [1:0] vc,
                                      input logic [15:0] wc);
    return {8'h00, wc, vc, dt};
  endfunction

  function automatic beat_t mk_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                                    input logic u, input logic [1:0] id);
    beat_t b;
    b.id = id; b.dest = 2'b00; b.user = u; b.last = l; b.keep = s; b.strb = s; b.data = d;
    return b;
  endfunction

  // Output-side ready driver for instance A
  initial begin
    a_out.tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (tready_mode)
        0:       a_out.tready = 1'b1;
        1:       a_out.tready = 1'($urandom_range(0, 1));
        default: a_out.tready = 1'b0;
      endcase
    end
  end

  // Handshakes are decided by values stable at the falling edge
  always @(negedge clk) begin
    if (rst_n && a_out.tvalid && a_out.tready) begin
      q_a.push_back({a_out.tid, a_out.tdest, a_out.tuser, a_out.tlast, a_out.tkeep,
                     a_out.tstrb, a_out.tdata});
    end
    if (err_a) err_cnt_a++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [31:0] d);
    logic rdy;
    int   t;
    a_in.tdata = d; a_in.tvalid = 1'b1; rdy = 1'b0; t = 0;
    while (!rdy && t < 500) begin
      @(negedge clk); rdy = a_in.tready;
      @(posedge clk); #1; t++;
    end
    a_in.tvalid = 1'b0;
    if (!rdy) check("send_a_accept", 64'(rdy), 64'd1);
  endtask

  task automatic send_b(input logic [63:0] d);
    logic rdy;
    int   t;
    b_in.tdata = d; b_in.tvalid = 1'b1; rdy = 1'b0; t = 0;
    while (!rdy && t < 500) begin
      @(negedge clk); rdy = b_in.tready;
      @(posedge clk); #1; t++;
    end
    b_in.tvalid = 1'b0;
    if (!rdy) check("send_b_accept", 64'(rdy), 64'd1);
  endtask

  task automatic expect_beat(input string tag, input beat_t exp);
    beat_t got;
    check({tag, "_avail"}, 64'(q_a.size() != 0), 64'd1);
    if (q_a.size() != 0) begin
      got = q_a.pop_front();
      check(tag, 64'(got), 64'(exp));
    end
  endtask

  initial begin
    a_in.tvalid = 1'b0; a_in.tdata = '0; a_in.tstrb = '1; a_in.tkeep = '1;
    a_in.tlast = 1'b0; a_in.tid = '0; a_in.tdest = '0; a_in.tuser = '0;
    b_in.tvalid = 1'b0; b_in.tdata = '0; b_in.tstrb = '1; b_in.tkeep = '1;
    b_in.tlast = 1'b0; b_in.tid = '0; b_in.tdest = '0; b_in.tuser = '0;

    // Reset state
    idle(3);
    check("rst_out_a", {a_out.tvalid, a_out.tlast, a_out.tuser, a_out.tstrb}, 0);
    check("rst_out_b", {b_out.tvalid, b_out.tlast, b_out.tuser, b_out.tstrb}, 0);
    check("rst_pulses", {fs_a, fe_a, ls_a, le_a, err_a, fs_b, fe_b, ls_b, le_b, err_b}, 0);
    rst_n = 1'b1;
    idle(1);

    // 1: WC=6 -> full beat then 2-byte last beat, CRC inside it
    send_a(hdr(6'h2A, 2'd0, 16'd6));
    send_a(32'h11223344);
    check("t1_latency", 64'(a_out.tvalid), 64'd1);
    send_a(32'hCCCC5566);
    idle(3);
    expect_beat("t1_b0", mk_beat(32'h11223344, 4'hF, 1'b0, 1'b1, 2'd0));
    expect_beat("t1_b1", mk_beat(32'hCCCC5566, 4'h3, 1'b1, 1'b0, 2'd0));
    check("t1_count", 64'(q_a.size()), 64'd0);

    // 2: WC=8 -> two full beats, the all-CRC beat is swallowed
    send_a(hdr(6'h2B, 2'd0, 16'd8));
    send_a(32'hAAAA0001);
    send_a(32'hAAAA0002);
    send_a(32'h0000BEEF);
    send_a(hdr(6'h00, 2'd0, 16'd0));
    check("t2_idle_fs", 64'(fs_a), 64'h1);
    idle(3);
    expect_beat("t2_b0", mk_beat(32'hAAAA0001, 4'hF, 1'b0, 1'b1, 2'd0));
    expect_beat("t2_b1", mk_beat(32'hAAAA0002, 4'hF, 1'b1, 1'b0, 2'd0));
    check("t2_no_crc", 64'(q_a.size()), 64'd0);

    // 4: FS then FE on VC2 (masked VC still pulses)
    send_a(hdr(6'h00, 2'd2, 16'd0));
    check("t4_fs", {fs_a, fe_a}, {4'b0100, 4'b0000});
    send_a(hdr(6'h01, 2'd2, 16'd0));
    check("t4_fe", {fs_a, fe_a}, {4'b0000, 4'b0100});
    idle(1);
    check("t4_fe_gone", {fs_a, fe_a, ls_a, le_a}, 0);

    // 5: masked VC1 dropped silently, VC0 follows intact, oversize flags error
    send_a(hdr(6'h2A, 2'd1, 16'd8));
    send_a(32'h00000080);
    send_a(32'h00000040);
    send_a(32'h0000C0C0);
    send_a(hdr(6'h2A, 2'd0, 16'd6));
    send_a(32'h12345678);
    send_a(32'hFFFF9ABC);
    idle(3);
    check("t5_no_err", 64'(err_cnt_a), 64'd0);
    expect_beat("t5_b0", mk_beat(32'h12345678, 4'hF, 1'b0, 1'b1, 2'd0));
    expect_beat("t5_b1", mk_beat(32'hFFFF9ABC, 4'h3, 1'b1, 1'b0, 2'd0));
    send_a(hdr(6'h2A, 2'd0, 16'd17));
    check("t5_err_pulse", 64'(err_a), 64'd1);
    send_a(32'h00000001);
    check("t5_err_1cyc", 64'(err_a), 64'd0);
    for (int i = 2; i <= 5; i++) send_a(32'(i));
    send_a(hdr(6'h01, 2'd0, 16'd0));
    check("t5_idle_fe", 64'(fe_a), 64'h1);
    idle(3);
    check("t5_dropped", 64'(q_a.size()), 64'd0);
    check("t5_err_cnt", 64'(err_cnt_a), 64'd1);

    // 6a: random backpressure across two packets
    tready_mode = 1;
    send_a(hdr(6'h2A, 2'd0, 16'd16));
    for (int i = 0; i < 4; i++) send_a(32'hA0000000 | 32'(i));
    send_a(32'h0000C3C3);
    send_a(hdr(6'h2A, 2'd0, 16'd10));
    for (int i = 0; i < 3; i++) send_a(32'hB0000000 | 32'(i));
    for (int t = 0; t < 300 && q_a.size() < 7; t++) @(posedge clk);
    idle(4);
    check("t6_count", 64'(q_a.size()), 64'd7);
    expect_beat("t6_p0b0", mk_beat(32'hA0000000, 4'hF, 1'b0, 1'b1, 2'd0));
    expect_beat("t6_p0b1", mk_beat(32'hA0000001, 4'hF, 1'b0, 1'b0, 2'd0));
    expect_beat("t6_p0b2", mk_beat(32'hA0000002, 4'hF, 1'b0, 1'b0, 2'd0));
    expect_beat("t6_p0b3", mk_beat(32'hA0000003, 4'hF, 1'b1, 1'b0, 2'd0));
    expect_beat("t6_p1b0", mk_beat(32'hB0000000, 4'hF, 1'b0, 1'b1, 2'd0));
    expect_beat("t6_p1b1", mk_beat(32'hB0000001, 4'hF, 1'b0, 1'b0, 2'd0));
    expect_beat("t6_p1b2", mk_beat(32'hB0000002, 4'h3, 1'b1, 1'b0, 2'd0));
    tready_mode = 0;
    idle(2);

    // 6b: output holds under backpressure, then reset mid-packet
    send_a(hdr(6'h2A, 2'd0, 16'd16));
    send_a(32'hD00D0000);
    tready_mode = 2;
    a_in.tdata = 32'hD00D0001; a_in.tvalid = 1'b1;
    idle(1);
    check("t6_hold1", {a_out.tvalid, a_out.tdata}, {1'b1, 32'hD00D0000});
    idle(1);
    check("t6_hold2", {a_out.tvalid, a_out.tdata, a_out.tuser}, {1'b1, 32'hD00D0000, 1'b1});
    rst_n = 1'b0;
    a_in.tvalid = 1'b0;
    #1;
    check("t6_rst_out", {a_out.tvalid, a_out.tlast, a_out.tuser, a_out.tstrb}, 0);
    check("t6_rst_pulse", {fs_a, fe_a, ls_a, le_a, err_a}, 0);
    idle(2);
    rst_n = 1'b1;
    tready_mode = 0;
    idle(1);
    send_a(hdr(6'h03, 2'd1, 16'd0));
    check("t6_post_rst_le", {le_a, ls_a}, {4'b0010, 4'b0000});
    idle(3);
    check("t6_no_stray", 64'(q_a.size()), 64'd0);

    // 3: 8-byte beats, WC=7 spills CRC, WC=5 does not
    send_b({32'h0, hdr(6'h2B, 2'd0, 16'd7)});
    send_b(64'h0011223344556677);
    check("t3_wc7_ctl", {b_out.tvalid, b_out.tlast, b_out.tuser, b_out.tstrb},
          {1'b1, 1'b1, 1'b1, 8'h7F});
    check("t3_wc7_data", b_out.tdata, 64'h0011223344556677);
    send_b(64'hDEADBEEFDEADBEEF);
    check("t3_crc_drop", 64'(b_out.tvalid), 64'd0);
    send_b({32'h0, hdr(6'h2B, 2'd3, 16'd5)});
    send_b(64'hFFFFFF0102030405);
    check("t3_wc5_ctl", {b_out.tvalid, b_out.tlast, b_out.tuser, b_out.tstrb, b_out.tid},
          {1'b1, 1'b1, 1'b1, 8'h1F, 2'd3});
    send_b({32'h0, hdr(6'h00, 2'd3, 16'd0)});
    check("t3_no_crc_fs", 64'(fs_b), 64'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
